// File: rtl/unlock_code_tx.sv
// unlock_code_tx: serial pattern transmitter for the pattern-unlock path.
// Sends code_reg MSB first, one bit per clock, repeated a programmable number
// of times with a fixed idle gap between copies, under a start/busy/done
// handshake.
module unlock_code_tx #(
    parameter int CODE_W = 3,
    parameter int GAP    = 2,
    parameter int REP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code_in,
    input  logic [REP_W-1:0]  reps,
    output logic              out,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BW-1:0]    BIT_LOAD = BW'(CODE_W - 1);
    localparam logic [GW-1:0]    GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state, state_n;
    logic [CODE_W-1:0] code_reg, code_n;
    logic [BW-1:0]     bit_idx, bit_n;
    logic [REP_W-1:0]  rep_left, rep_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic              out_n, valid_n, busy_n, done_n;

    // State, counters and registered outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            code_reg <= '0;
            bit_idx  <= '0;
            rep_left <= '0;
            gap_cnt  <= '0;
            out      <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            code_reg <= code_n;
            bit_idx  <= bit_n;
            rep_left <= rep_n;
            gap_cnt  <= gap_n;
            out      <= out_n;
            valid    <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and counter updates; outputs are decoded from the next
    // state so that the registered outputs line up with the state they describe.
    always_comb begin
        state_n = state;
        code_n  = code_reg;
        bit_n   = bit_idx;
        rep_n   = rep_left;
        gap_n   = gap_cnt;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    code_n  = code_in;
                    rep_n   = (reps == '0) ? REP_ONE : reps;
                    bit_n   = BIT_LOAD;
                    state_n = ST_SEND;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bit_idx != '0) begin
                    bit_n = bit_idx - 1'b1;
                end else if (rep_left > REP_ONE) begin
                    rep_n = rep_left - 1'b1;
                    bit_n = BIT_LOAD;
                    if (GAP == 0) begin
                        state_n = ST_SEND;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = GAP_LOAD;
                    end
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_SEND;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        out_n   = (state_n == ST_SEND) ? code_n[bit_n] : 1'b0;
        valid_n = (state_n == ST_SEND);
        busy_n  = (state_n == ST_SEND) || (state_n == ST_GAP);
        done_n  = (state_n == ST_DONE);
    end

endmodule

// File: tb/tb_unlock_code_tx.sv
// Directed bench for unlock_code_tx: expected {out,valid,busy,done} per cycle
// are queued ahead of each step and popped as the DUT outputs are sampled.
module tb_unlock_code_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] code_a = '0, code_b = '0;
    logic [2:0] reps_a = '0, reps_b = '0;
    logic       out_a, valid_a, busy_a, done_a;
    logic       out_b, valid_b, busy_b, done_b;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [3:0]  exp_q[$];

    unlock_code_tx #(.CODE_W(3), .GAP(2), .REP_W(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .code_in(code_a), .reps(reps_a),
        .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a)
    );

    unlock_code_tx #(.CODE_W(3), .GAP(0), .REP_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .code_in(code_b), .reps(reps_b),
        .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %b, expected entry missing", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b (out,valid,busy,done)", tag, obs, e);
            end
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic cyc(input string tag, input bit sel_b);
        @(posedge clk);
        #1;
        if (sel_b) check(tag, {out_b, valid_b, busy_b, done_b});
        else       check(tag, {out_a, valid_a, busy_a, done_a});
    endtask

    initial begin
        // Reset state
        push(4'b0000); cyc("reset_a", 0);
        push(4'b0000); check("reset_b", {out_b, valid_b, busy_b, done_b});
        rst = 1'b0;

        // Single copy of 110
        code_a = 3'b110; reps_a = 3'd1; start_a = 1'b1;
        push(4'b1110); push(4'b1110); push(4'b0110); push(4'b0001); push(4'b0000);
        cyc("single_b2", 0);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) cyc("single", 0);

        // Two copies with the two-cycle gap
        code_a = 3'b110; reps_a = 3'd2; start_a = 1'b1;
        push(4'b1110); push(4'b1110); push(4'b0110); push(4'b0010); push(4'b0010);
        push(4'b1110); push(4'b1110); push(4'b0110); push(4'b0001); push(4'b0000);
        cyc("rep2", 0);
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) cyc("rep2", 0);

        // reps=0 acts as one copy; start held and code_in toggled while busy
        code_a = 3'b101; reps_a = 3'd0; start_a = 1'b1;
        push(4'b1110); push(4'b0110); push(4'b1110); push(4'b0001);
        push(4'b0000); push(4'b0000);
        cyc("reps0", 0);
        code_a = 3'b010; cyc("reps0_hold", 0);
        code_a = 3'b111; reps_a = 3'd5; cyc("reps0_hold", 0);
        cyc("reps0_done", 0);
        start_a = 1'b0;
        cyc("reps0_idle", 0);
        cyc("reps0_idle", 0);

        // Reset on the second bit of a three-copy transfer
        code_a = 3'b110; reps_a = 3'd3; start_a = 1'b1;
        push(4'b1110); push(4'b1110);
        cyc("abort_b2", 0);
        start_a = 1'b0;
        cyc("abort_b1", 0);
        rst = 1'b1;
        push(4'b0000); cyc("abort_rst", 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(4'b0000); cyc("abort_nodone", 0);
        end
        code_a = 3'b011; reps_a = 3'd1; start_a = 1'b1;
        push(4'b0110); push(4'b1110); push(4'b1110); push(4'b0001); push(4'b0000);
        cyc("fresh", 0);
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) cyc("fresh", 0);

        // start held continuously: re-accepted in the done cycle
        code_a = 3'b110; reps_a = 3'd1; start_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(4'b1110); push(4'b1110); push(4'b0110); push(4'b0001);
        end
        for (int i = 0; i < 8; i++) cyc("stream", 0);
        start_a = 1'b0;
        push(4'b0000); cyc("stream_end", 0);

        // No-gap build: three copies back to back
        code_b = 3'b110; reps_b = 3'd3; start_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(4'b1110); push(4'b1110); push(4'b0110);
        end
        push(4'b0001); push(4'b0000);
        cyc("gap0", 1);
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) cyc("gap0", 1);

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: observed %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
